bus_command_arbiter: RTL and testbench

- Parametrised successor to the PCjr bus command/arbiter logic.
- Decodes CPU status strobes (ALE, RD_N, WR_N, IO_OR_M, DT_OR_R) into the four system commands IOW_N, MEMR_N, IOR_N, MEMW_N.
- Inserts a configurable number of wait states via a READY output.
- Arbitrates bus hold among NUM_REQ secondary masters (DMA, video, ...) with round-robin fairness.
- Sits between the CPU core and the system bus decode/peripheral fabric.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/hold_rr_picker.sv | 31 +++
 rtl/bus_command_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_command_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus command arbiter: FSM states,
// command-vector indices and the wait-state ceiling.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CMD  = 2'd2,
        HOLD = 2'd3
    } bus_state_t;

    localparam int CMD_IOR  = 0;
    localparam int CMD_IOW  = 1;
    localparam int CMD_MEMR = 2;
    localparam int CMD_MEMW = 3;

    localparam int MAX_WAIT = 15;

    // Select the active-low command slot from the latched cycle type/direction.
    function automatic logic [1:0] cmd_index(input logic io, input logic wr);
        if (io) begin
            return wr ? 2'(CMD_IOW) : 2'(CMD_IOR);
        end
        return wr ? 2'(CMD_MEMW) : 2'(CMD_MEMR);
    endfunction

endpackage

// File: rtl/hold_rr_picker.sv
// Combinational round-robin picker: scans requests starting at the pointer
// and returns the first one found as a one-hot grant plus its index.
module hold_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_grant_idx
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PW'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/bus_command_arbiter.sv
// Decodes CPU status strobes into system bus commands, inserts wait states
// via READY, and hands the bus to secondary masters with round-robin hold.
module bus_command_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int ADV_MEMR = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_clock_posedge,
    input  logic               cpu_clock_negedge,
    input  logic               RD_N,
    input  logic               WR_N,
    input  logic               IO_OR_M,
    input  logic               DT_OR_R,
    input  logic               ALE,
    input  logic [NUM_REQ-1:0] HOLD_REQ,
    output logic [NUM_REQ-1:0] HOLD_ACK,
    output logic               HLDA,
    output logic               READY,
    output logic               X_IO_OR_M,
    output logic               R_OR_DT,
    output logic               IOW_N,
    output logic               MEMR_N,
    output logic               IOR_N,
    output logic               MEMW_N,
    output logic [1:0]         o_dbg_state
);

    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MEM_W  = (MEM_WAIT > MAX_WAIT) ? MAX_WAIT : MEM_WAIT;
    localparam int IO_W   = (IO_WAIT > MAX_WAIT) ? MAX_WAIT : IO_WAIT;
    localparam int WMAX   = (MEM_W > IO_W) ? MEM_W : IO_W;
    localparam int WCW    = (WMAX > 0) ? $clog2(WMAX + 1) : 1;

    bus_state_t          r_state;
    logic                r_cyc_io;
    logic                r_cyc_wr;
    logic                r_early_memr;
    logic [WCW-1:0]      r_wait_cnt;
    logic [NUM_REQ-1:0]  r_hold_ack;
    logic [PW-1:0]       r_grant_idx;
    logic [PW-1:0]       r_rr_ptr;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PW-1:0]       w_grant_idx;
    logic                w_strobes_idle;
    logic [3:0]          w_cmd_n;

    hold_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .i_req       (HOLD_REQ),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_strobes_idle = RD_N && WR_N;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cyc_io     <= 1'b1;
            r_cyc_wr     <= 1'b0;
            r_early_memr <= 1'b0;
            r_wait_cnt   <= '0;
            r_hold_ack   <= '0;
            r_grant_idx  <= '0;
            r_rr_ptr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ALE) begin
                        r_cyc_io     <= IO_OR_M;
                        r_cyc_wr     <= DT_OR_R;
                        r_early_memr <= 1'b0;
                        r_state      <= ADDR;
                    end else if ((|HOLD_REQ) && cpu_clock_posedge) begin
                        r_hold_ack  <= w_grant;
                        r_grant_idx <= w_grant_idx;
                        r_state     <= HOLD;
                    end
                end
                ADDR: begin
                    if (ALE) begin
                        r_cyc_io     <= IO_OR_M;
                        r_cyc_wr     <= DT_OR_R;
                        r_early_memr <= 1'b0;
                    end else if (cpu_clock_negedge && (!RD_N || !WR_N)) begin
                        r_wait_cnt <= r_cyc_io ? WCW'(IO_W) : WCW'(MEM_W);
                        r_state    <= CMD;
                    end else if (cpu_clock_posedge && (ADV_MEMR != 0) &&
                                 !r_cyc_io && !r_cyc_wr) begin
                        r_early_memr <= 1'b1;
                    end
                end
                CMD: begin
                    if (w_strobes_idle) begin
                        r_wait_cnt   <= '0;
                        r_early_memr <= 1'b0;
                        r_state      <= IDLE;
                    end else if (cpu_clock_negedge && (r_wait_cnt != '0)) begin
                        r_wait_cnt <= r_wait_cnt - WCW'(1);
                    end
                end
                HOLD: begin
                    // Only the granted master's request matters until it lets go.
                    if (!HOLD_REQ[r_grant_idx]) begin
                        r_hold_ack <= '0;
                        r_rr_ptr   <= (r_grant_idx == PW'(NUM_REQ - 1)) ? '0
                                                                        : r_grant_idx + PW'(1);
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Commands derive from registered state, gated by the live strobes so
    // they release in the same clock the CPU ends the cycle.
    always_comb begin
        w_cmd_n = 4'b1111;
        if (r_state == CMD && !w_strobes_idle) begin
            w_cmd_n[cmd_index(r_cyc_io, r_cyc_wr)] = 1'b0;
        end
        if (r_state == ADDR && r_early_memr) begin
            w_cmd_n[CMD_MEMR] = 1'b0;
        end
    end

    assign IOR_N       = w_cmd_n[CMD_IOR];
    assign IOW_N       = w_cmd_n[CMD_IOW];
    assign MEMR_N      = w_cmd_n[CMD_MEMR];
    assign MEMW_N      = w_cmd_n[CMD_MEMW];
    assign READY       = !(r_state == CMD && r_wait_cnt != '0);
    assign HOLD_ACK    = r_hold_ack;
    assign HLDA        = |r_hold_ack;
    assign X_IO_OR_M   = (r_state == HOLD) || r_cyc_io;
    assign R_OR_DT     = (r_state == HOLD) || !r_cyc_wr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_command_arbiter.sv
// Directed bench for bus_command_arbiter: command decode, wait states,
// round-robin hold, deferral behind CPU cycles and asynchronous reset.
module tb_bus_command_arbiter;

    logic       clock;
    logic       reset;
    logic       cpu_clock_posedge;
    logic       cpu_clock_negedge;
    logic       RD_N;
    logic       WR_N;
    logic       IO_OR_M;
    logic       DT_OR_R;
    logic       ALE;
    logic [1:0] HOLD_REQ;
    logic [1:0] HOLD_ACK;
    logic       HLDA;
    logic       READY;
    logic       X_IO_OR_M;
    logic       R_OR_DT;
    logic       IOW_N;
    logic       MEMR_N;
    logic       IOR_N;
    logic       MEMW_N;
    logic [1:0] o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_CMD  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    bus_command_arbiter #(
        .NUM_REQ  (2),
        .MEM_WAIT (0),
        .IO_WAIT  (3),
        .ADV_MEMR (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .RD_N              (RD_N),
        .WR_N              (WR_N),
        .IO_OR_M           (IO_OR_M),
        .DT_OR_R           (DT_OR_R),
        .ALE               (ALE),
        .HOLD_REQ          (HOLD_REQ),
        .HOLD_ACK          (HOLD_ACK),
        .HLDA              (HLDA),
        .READY             (READY),
        .X_IO_OR_M         (X_IO_OR_M),
        .R_OR_DT           (R_OR_DT),
        .IOW_N             (IOW_N),
        .MEMR_N            (MEMR_N),
        .IOR_N             (IOR_N),
        .MEMW_N            (MEMW_N),
        .o_dbg_state       (o_dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One system clock with the given CPU-clock strobes; returns 1 time unit after the edge.
    task automatic clk(input logic pe, input logic ne);
        cpu_clock_posedge = pe;
        cpu_clock_negedge = ne;
        @(posedge clock);
        #1;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
    endtask

    // Commands packed as {IOW_N, MEMR_N, IOR_N, MEMW_N}.
    function automatic logic [7:0] cmds();
        return {4'b0, IOW_N, MEMR_N, IOR_N, MEMW_N};
    endfunction

    initial begin
        reset = 1'b1;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
        RD_N = 1'b1;
        WR_N = 1'b1;
        IO_OR_M = 1'b0;
        DT_OR_R = 1'b0;
        ALE = 1'b0;
        HOLD_REQ = 2'b00;

        // Reset values
        #2;
        chk("rst_cmds", cmds(), 8'h0f);
        chk("rst_ready", READY, 1'b1);
        chk("rst_ack", HOLD_ACK, 2'b00);
        chk("rst_hlda", HLDA, 1'b0);
        chk("rst_xio", X_IO_OR_M, 1'b1);
        chk("rst_rdt", R_OR_DT, 1'b1);
        chk("rst_state", o_dbg_state, S_IDLE);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Memory read with early MEMR_N
        ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b0;
        clk(1'b0, 1'b0);
        chk("mr_addr_state", o_dbg_state, S_ADDR);
        chk("mr_addr_memr", MEMR_N, 1'b1);
        chk("mr_addr_xio", X_IO_OR_M, 1'b0);
        ALE = 1'b0;
        clk(1'b1, 1'b0);
        chk("mr_early_memr", MEMR_N, 1'b0);
        chk("mr_early_ready", READY, 1'b1);
        RD_N = 1'b0;
        clk(1'b0, 1'b1);
        chk("mr_cmd_state", o_dbg_state, S_CMD);
        chk("mr_cmd_cmds", cmds(), 8'h0b);
        chk("mr_cmd_ready", READY, 1'b1);
        clk(1'b1, 1'b0);
        chk("mr_cmd_ready2", READY, 1'b1);
        RD_N = 1'b1;
        #1;
        chk("mr_release_memr", MEMR_N, 1'b1);
        clk(1'b0, 1'b0);
        chk("mr_end_state", o_dbg_state, S_IDLE);
        chk("mr_end_cmds", cmds(), 8'h0f);

        // I/O write with three wait states
        ALE = 1'b1; IO_OR_M = 1'b1; DT_OR_R = 1'b1;
        clk(1'b0, 1'b0);
        chk("iw_addr_xio", X_IO_OR_M, 1'b1);
        chk("iw_addr_rdt", R_OR_DT, 1'b0);
        ALE = 1'b0;
        clk(1'b1, 1'b0);
        chk("iw_addr_cmds", cmds(), 8'h0f);
        WR_N = 1'b0;
        clk(1'b0, 1'b1);
        chk("iw_cmd_cmds", cmds(), 8'h07);
        chk("iw_cmd_ready", READY, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            clk(1'b1, 1'b0);
            chk("iw_wait_pos_ready", READY, 1'b0);
            clk(1'b0, 1'b1);
            chk("iw_wait_neg_ready", READY, (k == 3) ? 1'b1 : 1'b0);
        end
        chk("iw_wait_cmds", cmds(), 8'h07);
        WR_N = 1'b1;
        #1;
        chk("iw_release_cmds", cmds(), 8'h0f);
        clk(1'b0, 1'b0);
        chk("iw_end_state", o_dbg_state, S_IDLE);

        // Round-robin hold between two masters
        HOLD_REQ = 2'b11;
        clk(1'b0, 1'b0);
        chk("rr_no_strobe_ack", HOLD_ACK, 2'b00);
        clk(1'b1, 1'b0);
        chk("rr_first_ack", HOLD_ACK, 2'b01);
        chk("rr_first_hlda", HLDA, 1'b1);
        chk("rr_first_state", o_dbg_state, S_HOLD);
        chk("rr_hold_rdt", R_OR_DT, 1'b1);
        chk("rr_hold_cmds", cmds(), 8'h0f);
        clk(1'b1, 1'b0);
        chk("rr_sticky_ack", HOLD_ACK, 2'b01);
        HOLD_REQ = 2'b10;
        clk(1'b0, 1'b0);
        chk("rr_exit_state", o_dbg_state, S_IDLE);
        chk("rr_exit_hlda", HLDA, 1'b0);
        clk(1'b1, 1'b0);
        chk("rr_second_ack", HOLD_ACK, 2'b10);
        HOLD_REQ = 2'b01;
        clk(1'b0, 1'b0);
        chk("rr_exit2_ack", HOLD_ACK, 2'b00);
        HOLD_REQ = 2'b11;
        clk(1'b1, 1'b0);
        chk("rr_third_ack", HOLD_ACK, 2'b01);
        HOLD_REQ = 2'b00;
        clk(1'b0, 1'b0);
        chk("rr_exit3_state", o_dbg_state, S_IDLE);

        // Hold request deferred behind an in-flight I/O read
        ALE = 1'b1; IO_OR_M = 1'b1; DT_OR_R = 1'b0;
        clk(1'b0, 1'b0);
        ALE = 1'b0;
        RD_N = 1'b0;
        clk(1'b0, 1'b1);
        clk(1'b0, 1'b1);
        HOLD_REQ = 2'b10;
        clk(1'b1, 1'b0);
        chk("df_cmd_ack", HOLD_ACK, 2'b00);
        chk("df_cmd_cmds", cmds(), 8'h0d);
        chk("df_cmd_ready", READY, 1'b0);
        RD_N = 1'b1;
        #1;
        chk("df_release_cmds", cmds(), 8'h0f);
        clk(1'b1, 1'b0);
        chk("df_idle_ack", HOLD_ACK, 2'b00);
        chk("df_idle_state", o_dbg_state, S_IDLE);
        clk(1'b0, 1'b0);
        chk("df_nostrobe_ack", HOLD_ACK, 2'b00);
        clk(1'b1, 1'b0);
        chk("df_grant_ack", HOLD_ACK, 2'b10);
        chk("df_grant_xio", X_IO_OR_M, 1'b1);
        chk("df_grant_cmds", cmds(), 8'h0f);
        HOLD_REQ = 2'b00;
        clk(1'b0, 1'b0);

        // ALE and HOLD_REQ together: CPU memory write wins
        ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b1; HOLD_REQ = 2'b01;
        clk(1'b1, 1'b0);
        chk("sim_state", o_dbg_state, S_ADDR);
        chk("sim_ack", HOLD_ACK, 2'b00);
        ALE = 1'b0;
        WR_N = 1'b0;
        clk(1'b1, 1'b0);
        chk("sim_addr_memr", MEMR_N, 1'b1);
        clk(1'b0, 1'b1);
        chk("sim_cmd_cmds", cmds(), 8'h0e);
        chk("sim_cmd_ready", READY, 1'b1);
        chk("sim_cmd_ack", HOLD_ACK, 2'b00);
        WR_N = 1'b1;
        clk(1'b1, 1'b0);
        chk("sim_done_ack", HOLD_ACK, 2'b00);
        clk(1'b1, 1'b0);
        chk("sim_grant_ack", HOLD_ACK, 2'b01);
        HOLD_REQ = 2'b00;
        clk(1'b0, 1'b0);

        // Asynchronous reset in the middle of an I/O read
        ALE = 1'b1; IO_OR_M = 1'b1; DT_OR_R = 1'b0;
        clk(1'b0, 1'b0);
        ALE = 1'b0;
        RD_N = 1'b0;
        clk(1'b0, 1'b1);
        chk("ar_pre_ior", IOR_N, 1'b0);
        chk("ar_pre_ready", READY, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ior", IOR_N, 1'b1);
        chk("ar_ready", READY, 1'b1);
        chk("ar_ack", HOLD_ACK, 2'b00);
        chk("ar_xio", X_IO_OR_M, 1'b1);
        chk("ar_state", o_dbg_state, S_IDLE);
        RD_N = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b0;
        clk(1'b0, 1'b0);
        chk("ar_next_state", o_dbg_state, S_ADDR);
        chk("ar_next_xio", X_IO_OR_M, 1'b0);
        ALE = 1'b0;
        clk(1'b1, 1'b0);
        chk("ar_next_memr", MEMR_N, 1'b0);
        RD_N = 1'b0;
        clk(1'b0, 1'b1);
        RD_N = 1'b1;
        clk(1'b0, 1'b0);
        chk("ar_next_end", o_dbg_state, S_IDLE);
        HOLD_REQ = 2'b11;
        clk(1'b1, 1'b0);
        chk("ar_ptr_ack", HOLD_ACK, 2'b01);
        HOLD_REQ = 2'b00;
        clk(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
